// File: rtl/deserializer_align_pkg.sv
// Shared types and sizing helpers for the deserializer word-alignment controller.
// The optional lock-loss statistics counter is enabled with the ALIGN_STATS_EN macro.
package deserializer_align_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEARCH    = 3'd1,
        ST_SLIP_WAIT = 3'd2,
        ST_VERIFY    = 3'd3,
        ST_LOCKED    = 3'd4
    } align_state_t;

    // Default configuration of the controller
    localparam int unsigned DEF_D            = 8;
    localparam int unsigned DEF_S            = 4;
    localparam int unsigned DEF_LOCK_COUNT   = 8;
    localparam int unsigned DEF_UNLOCK_COUNT = 4;
    localparam int unsigned DEF_SLIP_SETTLE  = 2;

    // Counter widths for the default configuration
    localparam int unsigned MATCH_CNT_W = $clog2(DEF_LOCK_COUNT + 1);
    localparam int unsigned MISS_CNT_W  = $clog2(DEF_UNLOCK_COUNT + 1);
    localparam int unsigned TRIES_CNT_W = $clog2(DEF_S + 1);

    // A slip request lasts exactly one high_speed_clock cycle
    localparam int unsigned SLIP_PULSE_W = 1;

    // Bits needed to hold the values 0..max_val (never less than one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        if (max_val < 32'd1) begin
            w = 32'd1;
        end else begin
            w = $clog2(max_val + 32'd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/align_run_counter.sv
// Consecutive-event counter: clear restarts the run (counting the current event
// when increment is also high), increment saturates at THRESH, full flags the run length.
module align_run_counter
    import deserializer_align_pkg::*;
#(
    parameter int unsigned THRESH = 1,
    parameter int unsigned W      = cnt_width(THRESH)
) (
    input  logic         high_speed_clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         full_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next run length: restart, extend (saturating) or hold
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? W'(1'b1) : '0;
        end else if (inc_i && (count_q < W'(THRESH))) begin
            count_d = count_q + W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Run-length register
    always_ff @(posedge high_speed_clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q >= W'(THRESH));

endmodule

// File: rtl/deserializer_align_ctrl.sv
// Word-alignment controller for the 1:S lane deserializer. Searches for TRAIN_PATTERN
// by slipping the word boundary one lane at a time, verifies LOCK_COUNT consecutive
// matches, then forwards aligned words. Define ALIGN_STATS_EN to build the
// saturating lock_loss_count statistic; otherwise that port is tied to zero.
module deserializer_align_ctrl
    import deserializer_align_pkg::*;
#(
    parameter int unsigned     D             = DEF_D,
    parameter int unsigned     S             = DEF_S,
    parameter logic [D*S-1:0]  TRAIN_PATTERN = 32'hA1B2_C3D4,
    parameter int unsigned     LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int unsigned     UNLOCK_COUNT  = DEF_UNLOCK_COUNT,
    parameter int unsigned     SLIP_SETTLE   = DEF_SLIP_SETTLE
) (
    input  logic                 reset,
    input  logic                 high_speed_clock,
    input  logic                 enable,
    input  logic                 word_valid,
    input  logic [D*S-1:0]       word_in,
    input  logic                 train_mode,
    input  logic                 retrain,
    output logic                 slip,
    output logic                 locked,
    output logic                 align_error,
    output logic [$clog2(S)-1:0] slip_count,
    output logic                 aligned_valid,
    output logic [D*S-1:0]       aligned_data,
    output logic [15:0]          lock_loss_count
);

    localparam int unsigned SC_W     = $clog2(S);
    localparam int unsigned MATCH_W  = cnt_width(LOCK_COUNT);
    localparam int unsigned MISS_W   = cnt_width(UNLOCK_COUNT);
    localparam int unsigned TRIES_W  = cnt_width(S);
    localparam int unsigned SETTLE_W = cnt_width(SLIP_SETTLE);

    align_state_t         state_q;
    logic                 slip_q;
    logic                 locked_q;
    logic                 align_error_q;
    logic [SC_W-1:0]      slip_count_q;
    logic                 aligned_valid_q;
    logic [D*S-1:0]       aligned_data_q;
    logic [TRIES_W-1:0]   tries_q;
    logic [SETTLE_W-1:0]  settle_q;

    logic                 word_match_s;
    logic                 match_clr_s;
    logic                 match_inc_s;
    logic                 miss_clr_s;
    logic                 miss_inc_s;
    logic [MATCH_W-1:0]   match_cnt_s;
    logic                 match_full_s;
    logic                 match_last_s;
    logic [MISS_W-1:0]    miss_cnt_s;
    logic                 miss_full_s;
    logic                 miss_last_s;
    logic                 loss_s;

    assign word_match_s = (word_in == TRAIN_PATTERN);
    assign match_last_s = (match_cnt_s == MATCH_W'(LOCK_COUNT - 1));
    assign miss_last_s  = (miss_cnt_s == MISS_W'(UNLOCK_COUNT - 1));
    // A training miss that completes the run drops lock
    assign loss_s       = miss_inc_s && (miss_last_s || miss_full_s);

    // Run-counter control: match runs live in SEARCH/VERIFY, miss runs in LOCKED
    always_comb begin
        match_clr_s = 1'b1;
        match_inc_s = 1'b0;
        miss_clr_s  = 1'b1;
        miss_inc_s  = 1'b0;
        if (enable && !retrain) begin
            case (state_q)
                ST_SEARCH: begin
                    match_inc_s = word_valid && word_match_s;
                end
                ST_VERIFY: begin
                    match_clr_s = word_valid && !word_match_s;
                    match_inc_s = word_valid && word_match_s;
                end
                ST_LOCKED: begin
                    miss_clr_s = train_mode && word_valid && word_match_s;
                    miss_inc_s = train_mode && word_valid && !word_match_s;
                end
                default: begin
                    match_clr_s = 1'b1;
                    miss_clr_s  = 1'b1;
                end
            endcase
        end else begin
            match_clr_s = 1'b1;
            match_inc_s = 1'b0;
            miss_clr_s  = 1'b1;
            miss_inc_s  = 1'b0;
        end
    end

    align_run_counter #(.THRESH(LOCK_COUNT), .W(MATCH_W)) u_match_cnt (
        .high_speed_clock (high_speed_clock),
        .reset            (reset),
        .clr_i            (match_clr_s),
        .inc_i            (match_inc_s),
        .count_o          (match_cnt_s),
        .full_o           (match_full_s)
    );

    align_run_counter #(.THRESH(UNLOCK_COUNT), .W(MISS_W)) u_miss_cnt (
        .high_speed_clock (high_speed_clock),
        .reset            (reset),
        .clr_i            (miss_clr_s),
        .inc_i            (miss_inc_s),
        .count_o          (miss_cnt_s),
        .full_o           (miss_full_s)
    );

    // Alignment FSM with registered slip/lock/error/data outputs
    always_ff @(posedge high_speed_clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            slip_q          <= 1'b0;
            locked_q        <= 1'b0;
            align_error_q   <= 1'b0;
            slip_count_q    <= '0;
            aligned_valid_q <= 1'b0;
            aligned_data_q  <= '0;
            tries_q         <= '0;
            settle_q        <= '0;
        end else if (!enable) begin
            // Disable parks the controller; boundary offset and error history survive
            state_q         <= ST_IDLE;
            slip_q          <= 1'b0;
            locked_q        <= 1'b0;
            aligned_valid_q <= 1'b0;
            settle_q        <= '0;
        end else if (retrain && (state_q != ST_IDLE)) begin
            // Restart alignment from the current boundary; the pending word is dropped
            state_q         <= ST_SEARCH;
            slip_q          <= 1'b0;
            locked_q        <= 1'b0;
            aligned_valid_q <= 1'b0;
            align_error_q   <= 1'b0;
            tries_q         <= '0;
            settle_q        <= '0;
        end else begin
            slip_q          <= 1'b0;
            aligned_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (word_valid) begin
                        if (word_match_s) begin
                            state_q <= ST_VERIFY;
                        end else begin
                            slip_q       <= 1'b1;
                            slip_count_q <= (slip_count_q == SC_W'(S - 1)) ? '0
                                          : slip_count_q + SC_W'(1'b1);
                            if (tries_q == TRIES_W'(S - 1)) begin
                                align_error_q <= 1'b1;
                                tries_q       <= '0;
                            end else begin
                                tries_q <= tries_q + TRIES_W'(1'b1);
                            end
                            settle_q <= '0;
                            // Always pass through SLIP_WAIT so slips are never back-to-back
                            state_q  <= ST_SLIP_WAIT;
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    if (SLIP_SETTLE == 0) begin
                        state_q <= ST_SEARCH;
                    end else if (word_valid) begin
                        if (settle_q == SETTLE_W'(SLIP_SETTLE - 1)) begin
                            settle_q <= '0;
                            state_q  <= ST_SEARCH;
                        end else begin
                            settle_q <= settle_q + SETTLE_W'(1'b1);
                        end
                    end
                end
                ST_VERIFY: begin
                    // full is only already set here when LOCK_COUNT is 1
                    if (match_full_s || (word_valid && word_match_s && match_last_s)) begin
                        state_q       <= ST_LOCKED;
                        locked_q      <= 1'b1;
                        align_error_q <= 1'b0;
                        tries_q       <= '0;
                    end else if (word_valid && !word_match_s) begin
                        state_q <= ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (loss_s) begin
                        locked_q <= 1'b0;
                        state_q  <= ST_SEARCH;
                    end else begin
                        aligned_valid_q <= word_valid;
                        if (word_valid) begin
                            aligned_data_q <= word_in;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALIGN_STATS_EN
    logic [15:0] loss_cnt_q;

    // Saturating count of lock losses caused by training misses
    always_ff @(posedge high_speed_clock) begin
        if (reset) begin
            loss_cnt_q <= 16'h0000;
        end else if (loss_s && (loss_cnt_q != 16'hFFFF)) begin
            loss_cnt_q <= loss_cnt_q + 16'h0001;
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = 16'h0000;
`endif

    assign slip          = slip_q;
    assign locked        = locked_q;
    assign align_error   = align_error_q;
    assign slip_count    = slip_count_q;
    assign aligned_valid = aligned_valid_q;
    assign aligned_data  = aligned_data_q;

endmodule
